// File: rtl/latch_bank_ctrl_if.sv
// Requester, latch-bank and shadow-readback signals of latch_bank_ctrl.
// The master side is the requester/testbench side; the slave side is the controller.
interface latch_bank_ctrl_if #(
    parameter int DW = 8
);
    logic          req0;
    logic [1:0]    addr0;
    logic [DW-1:0] data0;
    logic          req1;
    logic [1:0]    addr1;
    logic [DW-1:0] data1;
    logic          ack0;
    logic          ack1;
    logic [3:0]    lat_c;
    logic [DW-1:0] lat_d;
    logic [1:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, rd_addr,
        input  ack0, ack1, lat_c, lat_d, rd_data, busy
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, rd_addr,
        output ack0, ack1, lat_c, lat_d, rd_data, busy
    );
endinterface

// File: rtl/latch_bank_ctrl.sv
// Write controller for four external D latches sharing one data bus.
// Two round-robin requesters; each write runs SETUP -> OPEN -> HOLD with registered outputs.
module latch_bank_ctrl #(
    parameter int DW = 8
) (
    input logic              clk,
    input logic              rst,
    latch_bank_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          gnt_q, gnt_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] lat_d_q, lat_d_d;
    logic [3:0]    lat_c_q, lat_c_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] shadow_q [4];
    logic [DW-1:0] shadow_d [4];

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // Next-state, arbitration and output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        lat_d_d = lat_d_q;
        lat_c_d = 4'b0000;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // The pointer only matters when both ask at once.
                    if (bus.req0 && bus.req1) begin
                        gnt_d = ptr_q;
                    end else begin
                        gnt_d = bus.req1;
                    end
                    ptr_d   = ~gnt_d;
                    addr_d  = gnt_d ? bus.addr1 : bus.addr0;
                    lat_d_d = gnt_d ? bus.data1 : bus.data0;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                lat_c_d = onehot4(addr_q);
                state_d = OPEN;
            end
            OPEN: begin
                shadow_d[addr_q] = lat_d_q;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= 2'd0;
            lat_d_q <= '0;
            lat_c_q <= 4'b0000;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            lat_d_q <= lat_d_d;
            lat_c_q <= lat_c_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign bus.lat_c   = lat_c_q;
    assign bus.lat_d   = lat_d_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.busy    = busy_q;
    assign bus.rd_data = shadow_q[bus.rd_addr];

endmodule
